// File: rtl/msu_regs_prefetch_if.sv
// Bus and fetch-engine signal bundle for the MSU register block.
// slave: the register block's view; master: the SNES bus / storage side.
interface msu_regs_prefetch_if;
  logic        ENABLE;
  logic        RD_N;
  logic        WR_N;
  logic        SYSCLKF_CE;
  logic [23:0] ADDR;
  logic [7:0]  DIN;
  logic [7:0]  DOUT;
  logic        MSU_SEL;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic        fetch_ack;
  logic [7:0]  fetch_data;

  modport slave (
    input  ENABLE, RD_N, WR_N, SYSCLKF_CE, ADDR, DIN, fetch_ack, fetch_data,
    output DOUT, MSU_SEL, fetch_addr, fetch_req
  );

  modport master (
    output ENABLE, RD_N, WR_N, SYSCLKF_CE, ADDR, DIN, fetch_ack, fetch_data,
    input  DOUT, MSU_SEL, fetch_addr, fetch_req
  );
endinterface

// File: rtl/msu_regs_prefetch.sv
// MSU-1 register block with a prefetch FIFO on the $2001 data port.
// A single-outstanding req/ack engine keeps the FIFO topped up from
// fetch_addr; a seek flushes the FIFO and holds data_busy until PREFILL
// bytes are buffered.
module msu_regs_prefetch #(
  parameter int          FIFO_DEPTH = 8,
  parameter int          PREFILL    = 4,
  parameter logic [11:0] ADDR_BASE  = 12'h200,
  parameter logic [2:0]  REVISION   = 3'd2
)(
  input  logic                        CLK,
  input  logic                        RST_N,
  msu_regs_prefetch_if.slave          bus,
  output logic [15:0]                 track_num,
  output logic                        track_request,
  input  logic                        track_mounting,
  output logic [7:0]                  volume,
  input  logic                        status_track_missing,
  output logic                        status_audio_repeat,
  output logic                        status_audio_playing,
  input  logic                        audio_stop,
  output logic                        data_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        data_underrun
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic [0:0]    state;
  logic          sel, wr, seek, rd_data, rd_data_q, pop_edge, push, pop;
  logic          discard, mount_q;
  logic [23:0]   seek_shadow;
  logic [7:0]    track_lsb;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          unused_addr;

  assign unused_addr = ^{bus.ADDR[23], bus.ADDR[21:16]};

  assign sel      = bus.ENABLE & ~bus.ADDR[22] & (bus.ADDR[15:4] == ADDR_BASE) & ~bus.ADDR[3];
  assign bus.MSU_SEL = sel;
  assign wr       = sel & bus.SYSCLKF_CE & ~bus.WR_N;
  assign seek     = wr & (bus.ADDR[2:0] == 3'd3);
  assign rd_data  = sel & ~bus.RD_N & (bus.ADDR[2:0] == 3'd1);
  // Pop at the end of the $2001 access so the byte stays on DOUT throughout it.
  assign pop_edge = rd_data_q & ~rd_data;
  assign pop      = pop_edge & ~data_busy & (fifo_level != '0);
  // A seek in the ack cycle wins: the returning byte belongs to the old stream.
  assign push     = (state == ST_REQ) & bus.fetch_ack & ~discard & ~seek;
  assign bus.fetch_req = (state == ST_REQ);

  // Fetch engine: one request in flight; discard flags a request made stale by a seek.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state          <= ST_IDLE;
      discard        <= 1'b0;
      bus.fetch_addr <= '0;
    end else begin
      if (state == ST_IDLE) begin
        if (fifo_level < DEPTH_L) state <= ST_REQ;
      end else if (bus.fetch_ack) begin
        state   <= ST_IDLE;
        discard <= 1'b0;
        if (push) bus.fetch_addr <= bus.fetch_addr + 32'd1;
      end else if (seek) begin
        discard <= 1'b1;
      end
      if (seek) bus.fetch_addr <= {bus.DIN, seek_shadow};
    end
  end

  // FIFO pointers and occupancy; a seek flushes everything.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else if (seek) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge CLK) begin
    if (RST_N && push) mem[wptr] <= bus.fetch_data;
  end

  // Busy tracking and underrun detection on the $2001 read edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_data_q     <= 1'b0;
      data_underrun <= 1'b0;
      data_busy     <= 1'b0;
    end else begin
      rd_data_q     <= rd_data;
      data_underrun <= pop_edge & ~data_busy & (fifo_level == '0);
      if (seek)                                     data_busy <= 1'b1;
      else if (data_busy && fifo_level >= PREFILL_L) data_busy <= 1'b0;
    end
  end

  // Register writes plus track/audio status; bus writes win over event clears.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      seek_shadow          <= '0;
      track_lsb            <= '0;
      track_num            <= '0;
      track_request        <= 1'b0;
      volume               <= '0;
      status_audio_repeat  <= 1'b0;
      status_audio_playing <= 1'b0;
      mount_q              <= 1'b0;
    end else begin
      mount_q <= track_mounting;
      if (wr && bus.ADDR[2:0] == 3'd0) seek_shadow[7:0]   <= bus.DIN;
      if (wr && bus.ADDR[2:0] == 3'd1) seek_shadow[15:8]  <= bus.DIN;
      if (wr && bus.ADDR[2:0] == 3'd2) seek_shadow[23:16] <= bus.DIN;
      if (wr && bus.ADDR[2:0] == 3'd4) track_lsb <= bus.DIN;
      if (wr && bus.ADDR[2:0] == 3'd6) volume    <= bus.DIN;
      if (wr && bus.ADDR[2:0] == 3'd5) begin
        track_num     <= {bus.DIN, track_lsb};
        track_request <= 1'b1;
      end else if (mount_q && !track_mounting) begin
        track_request <= 1'b0;
      end
      if (wr && bus.ADDR[2:0] == 3'd7) begin
        status_audio_repeat  <= bus.DIN[1];
        status_audio_playing <= bus.DIN[0];
      end else if (audio_stop) begin
        status_audio_playing <= 1'b0;
      end
    end
  end

  // Read data is registered every cycle from the low address bits.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bus.DOUT <= 8'h00;
    end else begin
      case (bus.ADDR[2:0])
        3'd0: bus.DOUT <= {data_busy, track_request, status_audio_repeat,
                           status_audio_playing, status_track_missing, REVISION};
        3'd1: bus.DOUT <= (data_busy || fifo_level == '0) ? 8'h00 : mem[rptr];
        3'd2: bus.DOUT <= 8'h53;
        3'd3: bus.DOUT <= 8'h2D;
        3'd4: bus.DOUT <= 8'h4D;
        3'd5: bus.DOUT <= 8'h53;
        3'd6: bus.DOUT <= 8'h55;
        default: bus.DOUT <= 8'h31;
      endcase
    end
  end
endmodule

// File: tb/tb_msu_regs_prefetch.sv
// Directed bench for msu_regs_prefetch: register map, prefetch FIFO
// ordering, seek discard, underrun and track/audio priority rules.
module tb_msu_regs_prefetch;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] track_num;
  logic        track_request;
  logic        track_mounting;
  logic [7:0]  volume;
  logic        status_track_missing;
  logic        status_audio_repeat;
  logic        status_audio_playing;
  logic        audio_stop;
  logic        data_busy;
  logic [3:0]  fifo_level;
  logic        data_underrun;

  msu_regs_prefetch_if bus ();

  msu_regs_prefetch dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .track_num(track_num), .track_request(track_request),
    .track_mounting(track_mounting), .volume(volume),
    .status_track_missing(status_track_missing),
    .status_audio_repeat(status_audio_repeat),
    .status_audio_playing(status_audio_playing),
    .audio_stop(audio_stop), .data_busy(data_busy),
    .fifo_level(fifo_level), .data_underrun(data_underrun)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  bit ack_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Storage model: answers each request 3 cycles later with data = addr[7:0].
  initial begin
    int cnt;
    cnt = 0;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 8'h00;
    forever begin
      @(negedge CLK);
      if (bus.fetch_ack) begin
        bus.fetch_ack = 1'b0;
        cnt = 0;
      end else if (bus.fetch_req && ack_en) begin
        cnt++;
        if (cnt == 3) begin
          bus.fetch_ack  = 1'b1;
          bus.fetch_data = bus.fetch_addr[7:0];
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge CLK); #1; end
  endtask

  task automatic wr(input logic [23:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    bus.ADDR = a; bus.DIN = d; bus.WR_N = 1'b0; bus.SYSCLKF_CE = 1'b1;
    @(posedge CLK); #1;
    bus.WR_N = 1'b1; bus.SYSCLKF_CE = 1'b0;
  endtask

  task automatic rd(input logic [23:0] a, output logic [7:0] d, output logic u);
    @(posedge CLK); #1;
    bus.ADDR = a; bus.RD_N = 1'b0;
    @(posedge CLK); #1;
    d = bus.DOUT; bus.RD_N = 1'b1;
    @(posedge CLK); #1;
    u = data_underrun;
  endtask

  task automatic wait_level(input logic [3:0] lvl, input string tag);
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      if (fifo_level == lvl) break;
    end
    chk(tag, {28'd0, fifo_level}, {28'd0, lvl});
  endtask

  task automatic read_expect(input string tag);
    logic [7:0] d;
    logic u;
    logic [7:0] e;
    rd(24'h002001, d, u);
    e = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
    chk(tag, {24'd0, d}, {24'd0, e});
    chk({tag, "_nounderrun"}, {31'd0, u}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic u;
    logic [7:0] id_str [8];
    id_str = '{8'h02, 8'h00, 8'h53, 8'h2D, 8'h4D, 8'h53, 8'h55, 8'h31};
    RST_N = 1'b0;
    bus.ENABLE = 1'b1; bus.RD_N = 1'b1; bus.WR_N = 1'b1; bus.SYSCLKF_CE = 1'b0;
    bus.ADDR = 24'h000000; bus.DIN = 8'h00;
    track_mounting = 1'b0; status_track_missing = 1'b0; audio_stop = 1'b0;
    cyc(3);
    chk("rst_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_dout", {24'd0, bus.DOUT}, 32'd0);
    chk("rst_busy", {31'd0, data_busy}, 32'd0);
    chk("rst_track_req", {31'd0, track_request}, 32'd0);
    RST_N = 1'b1;

    // Register map readback.
    for (int i = 0; i < 8; i++) begin
      rd(24'h002000 + 24'(i), d, u);
      chk($sformatf("id_%0d", i), {24'd0, d}, {24'd0, id_str[i]});
    end

    // Decode.
    @(posedge CLK); #1 bus.ADDR = 24'h802003;
    #1 chk("sel_bank80", {31'd0, bus.MSU_SEL}, 32'd1);
    bus.ADDR = 24'h402003;
    #1 chk("sel_bank40", {31'd0, bus.MSU_SEL}, 32'd0);
    bus.ADDR = 24'h002008;
    #1 chk("sel_addr8", {31'd0, bus.MSU_SEL}, 32'd0);

    // Seek to 0x10 while the power-on request is outstanding.
    wr(24'h002000, 8'h10); wr(24'h002001, 8'h00); wr(24'h002002, 8'h00); wr(24'h002003, 8'h00);
    chk("seek1_busy", {31'd0, data_busy}, 32'd1);
    chk("seek1_addr", bus.fetch_addr, 32'h10);
    chk("seek1_level", {28'd0, fifo_level}, 32'd0);
    for (int i = 0; i < 8; i++) sb.push_back(8'h10 + 8'(i));
    ack_en = 1'b1;
    wait_level(4'd4, "prefill_level");
    chk("prefill_busy_still", {31'd0, data_busy}, 32'd1);
    cyc(1);
    chk("prefill_busy_clear", {31'd0, data_busy}, 32'd0);
    wait_level(4'd8, "full_level");
    cyc(5);
    chk("full_req_idle", {31'd0, bus.fetch_req}, 32'd0);
    chk("full_addr", bus.fetch_addr, 32'h18);

    // Back-to-back data reads with concurrent refill.
    for (int i = 0; i < 8; i++) read_expect($sformatf("data_%0d", i));
    wait_level(4'd8, "refill_level");
    ack_en = 1'b0;
    sb.push_back(8'h18);
    read_expect("data_18");
    cyc(2);
    chk("pend_req", {31'd0, bus.fetch_req}, 32'd1);
    chk("pend_addr", bus.fetch_addr, 32'h20);

    // Seek to 0x200 with a request pending: its answer must be dropped.
    wr(24'h002000, 8'h00); wr(24'h002001, 8'h02); wr(24'h002002, 8'h00); wr(24'h002003, 8'h00);
    chk("seek2_level", {28'd0, fifo_level}, 32'd0);
    chk("seek2_busy", {31'd0, data_busy}, 32'd1);
    ack_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge CLK); #1;
      if (bus.fetch_ack) break;
    end
    chk("discard_ack_seen", {31'd0, bus.fetch_ack}, 32'd1);
    chk("discard_level", {28'd0, fifo_level}, 32'd0);
    chk("discard_addr", bus.fetch_addr, 32'h200);
    for (int i = 0; i < 8; i++) sb.push_back(8'(i));
    wait_level(4'd8, "seek2_full");
    chk("seek2_busy_clear", {31'd0, data_busy}, 32'd0);
    ack_en = 1'b0;
    for (int i = 0; i < 8; i++) read_expect($sformatf("seek2_data_%0d", i));

    // Underrun: empty, not busy.
    chk("under_pre_level", {28'd0, fifo_level}, 32'd0);
    rd(24'h002001, d, u);
    chk("under_dout", {24'd0, d}, 32'd0);
    chk("under_pulse", {31'd0, u}, 32'd1);
    cyc(1);
    chk("under_pulse_end", {31'd0, data_underrun}, 32'd0);
    chk("under_level", {28'd0, fifo_level}, 32'd0);

    // Track request vs mounting falling edge.
    track_mounting = 1'b1;
    cyc(2);
    wr(24'h002004, 8'h34);
    @(posedge CLK); #1;
    bus.ADDR = 24'h002005; bus.DIN = 8'h12; bus.WR_N = 1'b0; bus.SYSCLKF_CE = 1'b1;
    track_mounting = 1'b0;
    @(posedge CLK); #1;
    bus.WR_N = 1'b1; bus.SYSCLKF_CE = 1'b0;
    chk("trk_req_wins", {31'd0, track_request}, 32'd1);
    chk("trk_num", {16'd0, track_num}, 32'h1234);
    track_mounting = 1'b1;
    cyc(1);
    track_mounting = 1'b0;
    cyc(2);
    chk("trk_req_clear", {31'd0, track_request}, 32'd0);

    // Audio control vs stop pulse.
    @(posedge CLK); #1;
    bus.ADDR = 24'h002007; bus.DIN = 8'h03; bus.WR_N = 1'b0; bus.SYSCLKF_CE = 1'b1;
    audio_stop = 1'b1;
    @(posedge CLK); #1;
    bus.WR_N = 1'b1; bus.SYSCLKF_CE = 1'b0; audio_stop = 1'b0;
    chk("play_wins", {31'd0, status_audio_playing}, 32'd1);
    chk("repeat_set", {31'd0, status_audio_repeat}, 32'd1);
    status_track_missing = 1'b1;
    rd(24'h002000, d, u);
    chk("status_bits", {24'd0, d}, 32'h3A);
    @(posedge CLK); #1 audio_stop = 1'b1;
    @(posedge CLK); #1 audio_stop = 1'b0;
    chk("stop_clears", {31'd0, status_audio_playing}, 32'd0);
    wr(24'h002006, 8'h80);
    chk("volume", {24'd0, volume}, 32'h80);

    // Reset while a request is outstanding.
    chk("pre_rst_req", {31'd0, bus.fetch_req}, 32'd1);
    @(posedge CLK); #1 RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_req", {31'd0, bus.fetch_req}, 32'd0);
    chk("midrst_addr", bus.fetch_addr, 32'd0);
    chk("midrst_vol", {24'd0, volume}, 32'd0);
    RST_N = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
